decode_issue: RTL and testbench

- Decode/issue stage directly upstream of the register file.
- Accepts fetched ARM instructions over a valid/ready handshake and drives the register file read addresses and the PC+8 value for r15 reads.
- Tracks in-flight destination registers in a 16-bit scoreboard and stalls on hazards.
- Registers the decoded control fields so they leave one cycle later, aligned with the register file's one-cycle read data, for the execute stage.

---
 rtl/decode_issue.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_issue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue
//  Description : ARM decode/issue stage with a register scoreboard; drives the
//                register file read ports and registers decoded fields for EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue #(
    parameter logic [31:0] PC_OFFSET = 32'd8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] instr_pc_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [3:0]  r1_addr_o,
    output logic [3:0]  r2_addr_o,
    output logic [31:0] pc_o,
    input  logic        wb_en_i,
    input  logic [3:0]  wb_addr_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [3:0]  ex_cond_o,
    output logic [1:0]  ex_class_o,
    output logic [3:0]  ex_opcode_o,
    output logic        ex_set_flags_o,
    output logic        ex_load_o,
    output logic        ex_use_imm_o,
    output logic [31:0] ex_imm_o,
    output logic [3:0]  ex_rd_o,
    output logic        ex_wr_en_o,
    output logic [31:0] ex_pc_o
);

    localparam logic [1:0] c_CLS_DP    = 2'b00;
    localparam logic [1:0] c_CLS_LS    = 2'b01;
    localparam logic [1:0] c_CLS_BR    = 2'b10;
    localparam logic [1:0] c_CLS_OTHER = 2'b11;

    logic [1:0]  w_cls;
    logic [3:0]  w_op;
    logic        w_s;
    logic        w_ld;
    logic        w_ui;
    logic [31:0] w_imm;
    logic [3:0]  w_rd;
    logic        w_we;
    logic        w_r1e;
    logic        w_r2e;
    logic [3:0]  w_r1;
    logic [3:0]  w_r2;
    logic [4:0]  w_rot;
    logic [31:0] w_imm8;
    logic [31:0] w_rot_imm;
    logic        w_hold;
    logic        w_hazard;
    logic        w_accept;
    logic [15:0] w_busy_nxt;

    logic        r_ex_valid;
    logic [3:0]  r_ex_cond;
    logic [1:0]  r_ex_class;
    logic [3:0]  r_ex_opcode;
    logic        r_ex_set_flags;
    logic        r_ex_load;
    logic        r_ex_use_imm;
    logic [31:0] r_ex_imm;
    logic [3:0]  r_ex_rd;
    logic        r_ex_wr_en;
    logic [31:0] r_ex_pc;
    logic [3:0]  r_ex_r1;
    logic [3:0]  r_ex_r2;
    logic [15:0] r_busy;

    assign w_rot     = {instr_i[11:8], 1'b0};
    assign w_imm8    = {24'd0, instr_i[7:0]};
    // A rotate of zero shifts left by 32, which yields zero and leaves imm8 intact.
    assign w_rot_imm = (w_imm8 >> w_rot) | (w_imm8 << (6'd32 - {1'b0, w_rot}));

    always_comb begin
        w_cls = c_CLS_OTHER;
        w_op  = 4'd0;
        w_s   = 1'b0;
        w_ld  = 1'b0;
        w_ui  = 1'b0;
        w_imm = 32'd0;
        w_rd  = 4'd0;
        w_we  = 1'b0;
        w_r1e = 1'b0;
        w_r2e = 1'b0;
        w_r1  = 4'd0;
        w_r2  = 4'd0;
        if (instr_i[27:26] == 2'b00) begin
            w_cls = c_CLS_DP;
            w_op  = instr_i[24:21];
            w_s   = instr_i[20];
            w_rd  = instr_i[15:12];
            w_we  = (instr_i[24:23] != 2'b10);
            if (instr_i[24:21] != 4'b1101 && instr_i[24:21] != 4'b1111) begin
                w_r1e = 1'b1;
                w_r1  = instr_i[19:16];
            end
            if (instr_i[25]) begin
                w_ui  = 1'b1;
                w_imm = w_rot_imm;
            end else begin
                w_r2e = 1'b1;
                w_r2  = instr_i[3:0];
            end
        end else if (instr_i[27:26] == 2'b01) begin
            w_cls = c_CLS_LS;
            w_ld  = instr_i[20];
            w_rd  = instr_i[15:12];
            w_we  = instr_i[20];
            w_r1e = 1'b1;
            w_r1  = instr_i[19:16];
            if (instr_i[25]) begin
                w_r2e = 1'b1;
                w_r2  = instr_i[3:0];
            end else begin
                w_ui  = 1'b1;
                w_imm = {20'd0, instr_i[11:0]};
                if (!instr_i[20]) begin
                    w_r2e = 1'b1;
                    w_r2  = instr_i[15:12];
                end
            end
        end else if (instr_i[27:25] == 3'b101) begin
            w_cls = c_CLS_BR;
            w_imm = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
            if (instr_i[24]) begin
                w_we = 1'b1;
                w_rd = 4'd14;
            end
        end
    end

    assign w_hold   = r_ex_valid & ~ex_ready_i;
    // busy[15] is held at zero, so r15 reads and writes never stall.
    assign w_hazard = instr_valid_i & ((w_r1e & r_busy[w_r1]) |
                                       (w_r2e & r_busy[w_r2]) |
                                       (w_we  & r_busy[w_rd]));
    assign instr_ready_o = ~w_hazard & ~w_hold;
    assign w_accept      = instr_valid_i & instr_ready_o & ~flush_i;

    assign r1_addr_o = w_hold ? r_ex_r1 : w_r1;
    assign r2_addr_o = w_hold ? r_ex_r2 : w_r2;
    assign pc_o      = (w_hold ? r_ex_pc : instr_pc_i) + PC_OFFSET;

    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en_i) begin
            w_busy_nxt[wb_addr_i] = 1'b0;
        end
        if (flush_i && r_ex_valid && r_ex_wr_en) begin
            w_busy_nxt[r_ex_rd] = 1'b0;
        end
        if (w_accept && w_we) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[15] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_valid     <= 1'b0;
            r_ex_cond      <= 4'd0;
            r_ex_class     <= 2'd0;
            r_ex_opcode    <= 4'd0;
            r_ex_set_flags <= 1'b0;
            r_ex_load      <= 1'b0;
            r_ex_use_imm   <= 1'b0;
            r_ex_imm       <= 32'd0;
            r_ex_rd        <= 4'd0;
            r_ex_wr_en     <= 1'b0;
            r_ex_pc        <= 32'd0;
            r_ex_r1        <= 4'd0;
            r_ex_r2        <= 4'd0;
            r_busy         <= 16'd0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_ex_cond      <= instr_i[31:28];
                r_ex_class     <= w_cls;
                r_ex_opcode    <= w_op;
                r_ex_set_flags <= w_s;
                r_ex_load      <= w_ld;
                r_ex_use_imm   <= w_ui;
                r_ex_imm       <= w_imm;
                r_ex_rd        <= w_rd;
                r_ex_wr_en     <= w_we;
                r_ex_pc        <= instr_pc_i;
                r_ex_r1        <= w_r1;
                r_ex_r2        <= w_r2;
            end
            if (flush_i) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid <= 1'b1;
            end else if (ex_ready_i) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign ex_valid_o     = r_ex_valid;
    assign ex_cond_o      = r_ex_cond;
    assign ex_class_o     = r_ex_class;
    assign ex_opcode_o    = r_ex_opcode;
    assign ex_set_flags_o = r_ex_set_flags;
    assign ex_load_o      = r_ex_load;
    assign ex_use_imm_o   = r_ex_use_imm;
    assign ex_imm_o       = r_ex_imm;
    assign ex_rd_o        = r_ex_rd;
    assign ex_wr_en_o     = r_ex_wr_en;
    assign ex_pc_o        = r_ex_pc;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_issue
//  Description : Directed bench for decode_issue with a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ival;
    logic        exr;
    logic        fl;
    logic        wbe;
    logic [3:0]  wba;

    logic        instr_ready_o;
    logic [3:0]  r1_addr_o;
    logic [3:0]  r2_addr_o;
    logic [31:0] pc_o;
    logic        ex_valid_o;
    logic [3:0]  ex_cond_o;
    logic [1:0]  ex_class_o;
    logic [3:0]  ex_opcode_o;
    logic        ex_set_flags_o;
    logic        ex_load_o;
    logic        ex_use_imm_o;
    logic [31:0] ex_imm_o;
    logic [3:0]  ex_rd_o;
    logic        ex_wr_en_o;
    logic [31:0] ex_pc_o;

    int n_vec = 0;
    int n_err = 0;

    decode_issue #(.PC_OFFSET(32'd8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_i        (instr),
        .instr_pc_i     (ipc),
        .instr_valid_i  (ival),
        .instr_ready_o  (instr_ready_o),
        .r1_addr_o      (r1_addr_o),
        .r2_addr_o      (r2_addr_o),
        .pc_o           (pc_o),
        .wb_en_i        (wbe),
        .wb_addr_i      (wba),
        .flush_i        (fl),
        .ex_valid_o     (ex_valid_o),
        .ex_ready_i     (exr),
        .ex_cond_o      (ex_cond_o),
        .ex_class_o     (ex_class_o),
        .ex_opcode_o    (ex_opcode_o),
        .ex_set_flags_o (ex_set_flags_o),
        .ex_load_o      (ex_load_o),
        .ex_use_imm_o   (ex_use_imm_o),
        .ex_imm_o       (ex_imm_o),
        .ex_rd_o        (ex_rd_o),
        .ex_wr_en_o     (ex_wr_en_o),
        .ex_pc_o        (ex_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cls;
        logic [3:0]  op;
        logic        s;
        logic        ld;
        logic        ui;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic        we;
        logic [3:0]  cond;
        logic        r1e;
        logic        r2e;
        logic [3:0]  r1;
        logic [3:0]  r2;
    } dec_t;

    // Reference model state: busy flags, held instruction, its pc.
    bit          mbusy [16];
    logic        mv = 1'b0;
    dec_t        mh = '0;
    logic [31:0] mpc = 32'd0;

    function automatic dec_t mdec(input logic [31:0] x);
        dec_t d;
        logic [63:0] dbl;
        int off;
        d = '0;
        d.cond = x[31:28];
        d.cls  = 2'b11;
        if (x[27:26] == 2'b00) begin
            d.cls = 2'b00;
            d.op  = x[24:21];
            d.s   = x[20];
            d.rd  = x[15:12];
            d.we  = !(d.op inside {[4'd8:4'd11]});
            if (!(d.op inside {4'd13, 4'd15})) begin
                d.r1e = 1'b1;
                d.r1  = x[19:16];
            end
            if (x[25]) begin
                d.ui  = 1'b1;
                dbl   = {32'(x[7:0]), 32'(x[7:0])} >> (2 * x[11:8]);
                d.imm = dbl[31:0];
            end else begin
                d.r2e = 1'b1;
                d.r2  = x[3:0];
            end
        end else if (x[27:26] == 2'b01) begin
            d.cls = 2'b01;
            d.ld  = x[20];
            d.we  = x[20];
            d.rd  = x[15:12];
            d.r1e = 1'b1;
            d.r1  = x[19:16];
            if (x[25]) begin
                d.r2e = 1'b1;
                d.r2  = x[3:0];
            end else begin
                d.ui  = 1'b1;
                d.imm = 32'(x[11:0]);
                if (!x[20]) begin
                    d.r2e = 1'b1;
                    d.r2  = x[15:12];
                end
            end
        end else if (x[27:25] == 3'b101) begin
            d.cls = 2'b10;
            off = int'({8'h00, x[23:0]});
            if (off >= (1 << 23)) off = off - (1 << 24);
            d.imm = 32'(off * 4);
            if (x[24]) begin
                d.we = 1'b1;
                d.rd = 4'd14;
            end
        end
        return d;
    endfunction

    function automatic bit m_ready();
        dec_t dc;
        bit haz;
        dc  = mdec(instr);
        haz = ival && ((dc.r1e && mbusy[dc.r1]) || (dc.r2e && mbusy[dc.r2]) ||
                       (dc.we && mbusy[dc.rd]));
        return !haz && !(mv && !exr);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        dec_t dc;
        bit hold;
        dc   = mdec(instr);
        hold = mv && !exr;
        chk("instr_ready", instr_ready_o, m_ready());
        chk("r1_addr", r1_addr_o, hold ? mh.r1 : dc.r1);
        chk("r2_addr", r2_addr_o, hold ? mh.r2 : dc.r2);
        chk("pc", pc_o, (hold ? mpc : ipc) + 32'd8);
        chk("ex_valid", ex_valid_o, mv);
        if (mv) begin
            chk("ex_cond", ex_cond_o, mh.cond);
            chk("ex_class", ex_class_o, mh.cls);
            chk("ex_opcode", ex_opcode_o, mh.op);
            chk("ex_set_flags", ex_set_flags_o, mh.s);
            chk("ex_load", ex_load_o, mh.ld);
            chk("ex_use_imm", ex_use_imm_o, mh.ui);
            chk("ex_imm", ex_imm_o, mh.imm);
            chk("ex_rd", ex_rd_o, mh.rd);
            chk("ex_wr_en", ex_wr_en_o, mh.we);
            chk("ex_pc", ex_pc_o, mpc);
        end
    endtask

    task automatic model_update();
        dec_t dc;
        bit acc;
        dc  = mdec(instr);
        acc = ival && m_ready() && !fl;
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mv  = 1'b0;
            mh  = '0;
            mpc = 32'd0;
        end else begin
            if (wbe) mbusy[wba] = 1'b0;
            if (fl && mv && mh.we) mbusy[mh.rd] = 1'b0;
            if (acc && dc.we && dc.rd != 4'd15) mbusy[dc.rd] = 1'b1;
            if (fl) mv = 1'b0;
            else if (acc) begin
                mv  = 1'b1;
                mh  = dc;
                mpc = ipc;
            end else if (exr) mv = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic issue(input logic [31:0] v, input logic [31:0] pc);
        bit done;
        done  = 1'b0;
        ival  = 1'b1;
        instr = v;
        ipc   = pc;
        for (int k = 0; k < 40 && !done; k++) begin
            wba = 4'(k);
            step();
            done = m_ready() && !fl && !rst;
            tick();
        end
        ival = 1'b0;
        chk("issue_accepted", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] tbl_instr [12] = '{32'hE5912004, 32'hE7876008, 32'hE58A9008, 32'hEB000010,
                                    32'hEAFFFFFE, 32'hEF000000, 32'hE3510000, 32'hE1E01002,
                                    32'hE1150006, 32'hE3A07E3F, 32'hE59DF000, 32'hE08F400F};
    logic [31:0] tbl_imm   [12] = '{32'h4, 32'h0, 32'h8, 32'h40,
                                    32'hFFFFFFF8, 32'h0, 32'h0, 32'h0,
                                    32'h0, 32'h3F0, 32'h0, 32'h0};
    logic [1:0]  tbl_cls   [12] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                                    2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        rst = 1'b1; ival = 1'b1; instr = 32'hE0813002; ipc = 32'h100;
        exr = 1'b1; fl = 1'b0; wbe = 1'b0; wba = 4'd0;

        // Reset with a valid instruction presented
        step(); chk("rst_ex_valid", ex_valid_o, 0); tick();
        step(); chk("rst_ex_valid2", ex_valid_o, 0); tick();
        rst = 1'b0;

        // ADD r3,r1,r2
        step();
        chk("add_ready", instr_ready_o, 1);
        chk("add_r1", r1_addr_o, 1);
        chk("add_r2", r2_addr_o, 2);
        chk("add_pc", pc_o, 32'h108);
        tick();

        // SUB r4,r3,#1 stalls on r3
        instr = 32'hE2434001; ipc = 32'h104;
        step();
        chk("add_ex_valid", ex_valid_o, 1);
        chk("add_ex_rd", ex_rd_o, 3);
        chk("add_ex_wr_en", ex_wr_en_o, 1);
        chk("add_ex_opcode", ex_opcode_o, 4'b0100);
        chk("raw_stall0", instr_ready_o, 0);
        tick();
        step(); chk("raw_stall1", instr_ready_o, 0); tick();
        wbe = 1'b1; wba = 4'd3;
        step(); chk("raw_stall_wb_edge", instr_ready_o, 0); tick();
        wbe = 1'b0;
        step(); chk("raw_release", instr_ready_o, 1); tick();
        ival = 1'b0;
        step();
        chk("sub_ex_valid", ex_valid_o, 1);
        chk("sub_ex_imm", ex_imm_o, 1);
        chk("sub_ex_use_imm", ex_use_imm_o, 1);
        chk("sub_ex_rd", ex_rd_o, 4);
        tick();

        // MOV r0,#0xFF000000 then 3 cycles of backpressure
        wbe = 1'b1; wba = 4'd4;
        ival = 1'b1; instr = 32'hE3A004FF; ipc = 32'h200; exr = 1'b0;
        step(); chk("mov_ready", instr_ready_o, 1); tick();
        wbe = 1'b0; instr = 32'hE0865007; ipc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ex_imm", ex_imm_o, 32'hFF000000);
            chk("bp_ex_rd", ex_rd_o, 0);
            chk("bp_r1", r1_addr_o, 0);
            chk("bp_r2", r2_addr_o, 0);
            chk("bp_ready", instr_ready_o, 0);
            chk("bp_pc", pc_o, 32'h208);
            tick();
        end

        // Hold ADD r3 then flush it
        exr = 1'b1; instr = 32'hE0813002; ipc = 32'h300;
        step(); chk("add2_ready", instr_ready_o, 1); tick();
        exr = 1'b0; ival = 1'b0;
        step();
        chk("hold_ex_rd", ex_rd_o, 3);
        chk("hold_r1", r1_addr_o, 1);
        chk("hold_r2", r2_addr_o, 2);
        chk("hold_pc", pc_o, 32'h308);
        tick();
        fl = 1'b1;
        step(); tick();
        fl = 1'b0; ival = 1'b1; instr = 32'hE2434001; ipc = 32'h310; exr = 1'b1;
        step();
        chk("flush_ex_valid", ex_valid_o, 0);
        chk("flush_no_stall", instr_ready_o, 1);
        tick();
        ival = 1'b0;
        step(); chk("post_flush_ex_rd", ex_rd_o, 4); tick();

        // Flush suppresses a same-edge accept of LDR r2
        ival = 1'b1; instr = 32'hE5912004; ipc = 32'h320; fl = 1'b1;
        step(); tick();
        fl = 1'b0; instr = 32'hE0823001; ipc = 32'h324;
        step();
        chk("supp_ex_valid", ex_valid_o, 0);
        chk("supp_no_busy_r2", instr_ready_o, 1);
        tick();
        ival = 1'b0;

        // Decode table with rotating writebacks
        wbe = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(tbl_instr[i], 32'h1000 + 32'(i * 4));
            step();
            chk("tbl_ex_imm", ex_imm_o, tbl_imm[i]);
            chk("tbl_ex_class", ex_class_o, tbl_cls[i]);
            tick();
        end

        // Reset in the middle of a hold plus stall
        wbe = 1'b0; exr = 1'b0;
        issue(32'hE0813002, 32'h2000);
        ival = 1'b1; instr = 32'hE2434001; ipc = 32'h2004;
        step(); chk("pre_rst_ready", instr_ready_o, 0); tick();
        rst = 1'b1;
        step(); tick();
        rst = 1'b0;
        step();
        chk("mid_rst_ex_valid", ex_valid_o, 0);
        chk("mid_rst_ready", instr_ready_o, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
